// File: rtl/shift_pkg.sv
// Shared types and elaboration helpers for the pipelined shift unit.
// Maps shift levels (shift by 2^j) onto pipeline stages.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2,
        SHIFT_ROR = 2'd3
    } shift_op_e;

    localparam int MAX_SHAMT_W = 6;

    function automatic int shamt_width(input int xlen);
        return $clog2(xlen);
    endfunction

    function automatic int level_stage(input int j, input int stages, input int levels);
        return (j * stages) / levels;
    endfunction

    // Levels land on stages monotonically, so each stage owns a contiguous range.
    function automatic int stage_first_lvl(input int k, input int stages, input int levels);
        int first;
        first = 0;
        for (int j = levels - 1; j >= 0; j--) begin
            if (level_stage(j, stages, levels) == k) first = j;
        end
        return first;
    endfunction

    function automatic int stage_num_lvl(input int k, input int stages, input int levels);
        int num;
        num = 0;
        for (int j = 0; j < levels; j++) begin
            if (level_stage(j, stages, levels) == k) num++;
        end
        return num;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline slice: applies levels FIRST_LVL..FIRST_LVL+NUM_LVL-1, then registers.
// Rotate is built only when SHIFT_PIPE_ROTATE_EN is defined; otherwise op 3 acts as SRL.
module shift_stage
    import shift_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int FIRST_LVL = 0,
    parameter int NUM_LVL   = 1,
    parameter int SW        = shamt_width(XLEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [1:0]       up_op,
    input  logic [XLEN-1:0]  up_data,
    input  logic [SW-1:0]    up_shamt,
    input  logic [TAG_W-1:0] up_tag,
    input  logic             down_advance,
    output logic             advance,
    output logic             valid_q,
    output logic [1:0]       op_q,
    output logic [XLEN-1:0]  data_q,
    output logic [SW-1:0]    shamt_q,
    output logic [TAG_W-1:0] tag_q
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = up_data;
        for (int l = 0; l < NUM_LVL; l++) begin
            if (up_shamt[FIRST_LVL + l]) begin
                case (shift_op_e'(up_op))
                    SHIFT_SLL: shifted = shifted << (1 << (FIRST_LVL + l));
                    SHIFT_SRA: shifted = $unsigned($signed(shifted) >>> (1 << (FIRST_LVL + l)));
`ifdef SHIFT_PIPE_ROTATE_EN
                    SHIFT_ROR: shifted = (shifted >> (1 << (FIRST_LVL + l)))
                                       | (shifted << (XLEN - (1 << (FIRST_LVL + l))));
`endif
                    default:   shifted = shifted >> (1 << (FIRST_LVL + l));
                endcase
            end
        end
    end

    // A full stage may only move when the stage below makes room.
    assign advance = !valid_q || down_advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            data_q  <= '0;
            shamt_q <= '0;
            tag_q   <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (advance) begin
                valid_q <= up_valid;
            end
            if (advance && up_valid && !flush) begin
                op_q    <= up_op;
                data_q  <= shifted;
                shamt_q <= up_shamt;
                tag_q   <= up_tag;
            end
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA(/ROR) unit with valid/ready handshake, tag pass-through and flush.
// Optional rotate datapath: define SHIFT_PIPE_ROTATE_EN.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 2,
    parameter int TAG_W      = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [1:0]               op_i,
    input  logic [XLEN-1:0]          a_i,
    input  logic [$clog2(XLEN)-1:0]  shamt_i,
    input  logic [TAG_W-1:0]         tag_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [XLEN-1:0]          res_o,
    output logic [TAG_W-1:0]         tag_o
);

    localparam int SW = shamt_width(XLEN);

    // Index k is the input of stage k; index NUM_STAGES is the output register.
    logic [NUM_STAGES:0]            valid_s;
    logic [NUM_STAGES:0]            adv_s;
    logic [NUM_STAGES:0][1:0]       op_s;
    logic [NUM_STAGES:0][XLEN-1:0]  data_s;
    logic [NUM_STAGES:0][SW-1:0]    shamt_s;
    logic [NUM_STAGES:0][TAG_W-1:0] tag_s;

    assign valid_s[0]          = in_valid_i;
    assign op_s[0]             = op_i;
    assign data_s[0]           = a_i;
    assign shamt_s[0]          = shamt_i;
    assign tag_s[0]            = tag_i;
    assign adv_s[NUM_STAGES]   = out_ready_i;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int FIRST = stage_first_lvl(k, NUM_STAGES, SW);
        localparam int NUM   = stage_num_lvl(k, NUM_STAGES, SW);

        shift_stage #(
            .XLEN      (XLEN),
            .TAG_W     (TAG_W),
            .FIRST_LVL (FIRST),
            .NUM_LVL   (NUM),
            .SW        (SW)
        ) u_stage (
            .clk          (clk_i),
            .rst_n        (rst_ni),
            .flush        (flush_i),
            .up_valid     (valid_s[k]),
            .up_op        (op_s[k]),
            .up_data      (data_s[k]),
            .up_shamt     (shamt_s[k]),
            .up_tag       (tag_s[k]),
            .down_advance (adv_s[k+1]),
            .advance      (adv_s[k]),
            .valid_q      (valid_s[k+1]),
            .op_q         (op_s[k+1]),
            .data_q       (data_s[k+1]),
            .shamt_q      (shamt_s[k+1]),
            .tag_q        (tag_s[k+1])
        );
    end

    assign in_ready_o  = adv_s[0];
    assign out_valid_o = valid_s[NUM_STAGES];
    assign res_o       = data_s[NUM_STAGES];
    assign tag_o       = tag_s[NUM_STAGES];

    logic unused_tail;
    assign unused_tail = ^{op_s[NUM_STAGES], shamt_s[NUM_STAGES]};

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe: 2-stage main instance plus 1- and 5-stage instances for latency.
// Expected ROR results follow SHIFT_PIPE_ROTATE_EN.
module tb_shift_pipe;
    import shift_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [4:0]  tag;
        logic [31:0] res;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [4:0]  tag;

    logic        in_ready,   out_valid;
    logic [31:0] res;
    logic [4:0]  res_tag;
    logic        in_ready_1, out_valid_1;
    logic [31:0] res_1;
    logic [4:0]  res_tag_1;
    logic        in_ready_5, out_valid_5;
    logic [31:0] res_5;
    logic [4:0]  res_tag_5;

    int checks = 0;
    int errors = 0;

    shift_pipe #(.XLEN(32), .NUM_STAGES(2), .TAG_W(5)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .op_i(op), .a_i(a), .shamt_i(shamt), .tag_i(tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .res_o(res), .tag_o(res_tag)
    );

    shift_pipe #(.XLEN(32), .NUM_STAGES(1), .TAG_W(5)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready_1), .op_i(op), .a_i(a), .shamt_i(shamt), .tag_i(tag),
        .out_valid_o(out_valid_1), .out_ready_i(out_ready), .res_o(res_1), .tag_o(res_tag_1)
    );

    shift_pipe #(.XLEN(32), .NUM_STAGES(5), .TAG_W(5)) u_dut5 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready_5), .op_i(op), .a_i(a), .shamt_i(shamt), .tag_i(tag),
        .out_valid_o(out_valid_5), .out_ready_i(out_ready), .res_o(res_5), .tag_o(res_tag_5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic checkLatency(input string name, input int e, input int lat, input logic v,
                                input logic [31:0] r, input logic [4:0] t, input vec_t x);
        checkOutput({name, "_valid"}, v, (e == lat));
        if (e == lat) begin
            checkOutput({name, "_res"}, r, x.res);
            checkOutput({name, "_tag"}, t, x.tag);
        end
    endtask

    // Issue one op with out_ready high and check each instance's result lands at its depth.
    task automatic applyStimulus(input vec_t x);
        @(negedge clk);
        op = x.op; a = x.a; shamt = x.shamt; tag = x.tag; in_valid = 1'b1;
        #1 checkOutput("accept_ready", in_ready, 1);
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checkLatency("lat2", e, 2, out_valid,   res,   res_tag,   x);
            checkLatency("lat1", e, 1, out_valid_1, res_1, res_tag_1, x);
            checkLatency("lat5", e, 5, out_valid_5, res_5, res_tag_5, x);
        end
    endtask

    vec_t vecs [0:10];
    vec_t sv   [0:2];
    vec_t fv   [0:3];

    initial begin
        int issued, got;
        int fcount, fit;
        logic [31:0] fres;
        logic [4:0]  ftag;
        vec_t g;

        vecs[0]  = '{SHIFT_SRA, 32'h8000_0010, 5'd4,  5'd3,  32'hF800_0001};
        vecs[1]  = '{SHIFT_SRL, 32'h8000_0010, 5'd4,  5'd4,  32'h0800_0001};
        vecs[2]  = '{SHIFT_SLL, 32'h0000_00FF, 5'd31, 5'd5,  32'h8000_0000};
        vecs[3]  = '{SHIFT_SLL, 32'h1234_5678, 5'd0,  5'd6,  32'h1234_5678};
        vecs[4]  = '{SHIFT_SRL, 32'h9ABC_DEF0, 5'd0,  5'd7,  32'h9ABC_DEF0};
        vecs[5]  = '{SHIFT_SRA, 32'h9ABC_DEF0, 5'd0,  5'd8,  32'h9ABC_DEF0};
        vecs[6]  = '{SHIFT_SRA, 32'h8000_0000, 5'd31, 5'd9,  32'hFFFF_FFFF};
        vecs[7]  = '{SHIFT_SRL, 32'h8000_0000, 5'd31, 5'd10, 32'h0000_0001};
`ifdef SHIFT_PIPE_ROTATE_EN
        vecs[8]  = '{SHIFT_ROR, 32'h0000_0001, 5'd1,  5'd11, 32'h8000_0000};
`else
        vecs[8]  = '{SHIFT_ROR, 32'h0000_0001, 5'd1,  5'd11, 32'h0000_0000};
`endif
        vecs[9]  = '{SHIFT_SRA, 32'h7FFF_FFFF, 5'd31, 5'd12, 32'h0000_0000};
        vecs[10] = '{SHIFT_SLL, 32'hA5A5_A5A5, 5'd8,  5'd13, 32'hA5A5_A500};

        sv[0] = '{SHIFT_SRL, 32'h0000_00F0, 5'd4, 5'd20, 32'h0000_000F};
        sv[1] = '{SHIFT_SLL, 32'h0000_0001, 5'd4, 5'd21, 32'h0000_0010};
        sv[2] = '{SHIFT_SRA, 32'h8000_0000, 5'd1, 5'd22, 32'hC000_0000};

        fv[0] = '{SHIFT_SLL, 32'h0000_0001, 5'd1, 5'd24, 32'h0000_0002};
        fv[1] = '{SHIFT_SLL, 32'h0000_0001, 5'd2, 5'd25, 32'h0000_0004};
        fv[2] = '{SHIFT_SLL, 32'h0000_0001, 5'd3, 5'd26, 32'h0000_0008};
        fv[3] = '{SHIFT_SRL, 32'hF000_0000, 5'd8, 5'd27, 32'h00F0_0000};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; shamt = '0; tag = '0;

        #3;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_res", res, 0);
        checkOutput("reset_tag", res_tag, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid_1", out_valid_1, 0);
        checkOutput("reset_out_valid_5", out_valid_5, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i <= 10; i++) applyStimulus(vecs[i]);

        // Back-to-back: op i visible two iterations after it is offered.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 8) begin
                op = SHIFT_SLL; a = 32'h0000_0101; shamt = 5'(c); tag = 5'(c); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 2) begin
                checkOutput("b2b_idle", out_valid, 0);
            end else begin
                checkOutput("b2b_valid", out_valid, 1);
                checkOutput("b2b_tag", res_tag, c - 2);
                checkOutput("b2b_res", res, 32'h0000_0101 << (c - 2));
            end
        end

        // Backpressure: consumer stalls for iterations 0..6, then drains.
        issued = 0; got = 0;
        for (int it = 0; it < 20; it++) begin
            @(negedge clk);
            out_ready = (it >= 7);
            if (issued < 3) begin
                op = sv[issued].op; a = sv[issued].a; shamt = sv[issued].shamt;
                tag = sv[issued].tag; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (it == 2) checkOutput("stall_accepts", issued, 2);
            if (it >= 2 && it <= 6) begin
                checkOutput("stall_in_ready", in_ready, 0);
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_res", res, sv[0].res);
                checkOutput("stall_tag", res_tag, sv[0].tag);
            end
            if (out_valid && out_ready) begin
                if (got < 3) begin
                    checkOutput("drain_res", res, sv[got].res);
                    checkOutput("drain_tag", res_tag, sv[got].tag);
                end
                got++;
            end
            if (in_valid && in_ready) issued++;
        end
        checkOutput("drain_count", got, 3);
        checkOutput("drain_issued", issued, 3);

        // Flush with two ops in flight and a third offered; a later op must return.
        fcount = 0; fit = -1; fres = '0; ftag = '0;
        for (int it = 0; it < 13; it++) begin
            @(negedge clk);
            out_ready = (it >= 3);
            flush = (it == 2);
            if (it <= 2 || it == 5) begin
                g = fv[(it == 5) ? 3 : it];
                op = g.op; a = g.a; shamt = g.shamt; tag = g.tag; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (it == 3) checkOutput("flush_out_valid", out_valid, 0);
            if (out_valid && out_ready) begin
                fcount++; fit = it; fres = res; ftag = res_tag;
            end
        end
        flush = 1'b0;
        checkOutput("flush_result_count", fcount, 1);
        checkOutput("flush_new_tag", ftag, fv[3].tag);
        checkOutput("flush_new_res", fres, fv[3].res);
        checkOutput("flush_new_latency", fit, 7);

        // Asynchronous reset in the middle of a clock phase.
        @(negedge clk);
        op = SHIFT_SRL; a = 32'h0000_00F0; shamt = 5'd4; tag = 5'd28; in_valid = 1'b1;
        @(negedge clk);
        tag = 5'd29;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput("pre_reset_valid", out_valid, 1);
        checkOutput("pre_reset_tag", res_tag, 28);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", out_valid, 0);
        checkOutput("async_reset_res", res, 0);
        checkOutput("async_reset_tag", res_tag, 0);
        checkOutput("async_reset_valid_5", out_valid_5, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("post_reset_in_ready", in_ready, 1);
        g = '{SHIFT_SLL, 32'h0000_0003, 5'd2, 5'd30, 32'h0000_000C};
        applyStimulus(g);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
